// File: rtl/link_fault_sequencer.sv
// Link fault sequencer for the reconciliation layer between the MAC-side XGMII
// and the PCS encoder. It watches the RX column stream for Local/Remote Fault
// sequence ordered sets and substitutes the TX column stream with Remote Fault
// or Idle columns while a fault is active. It only returns to passing MAC data
// on an all-idle column, so a partially sent frame never reaches the PCS.
module link_fault_sequencer #(
    parameter int unsigned WINDOW    = 128,
    parameter int unsigned THRESHOLD = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_rxd,
    input  logic [3:0]  i_rxc,
    input  logic        i_rx_valid,
    input  logic [31:0] i_txd,
    input  logic [3:0]  i_txc,
    input  logic        i_tx_valid,
    output logic [31:0] o_txd,
    output logic [3:0]  o_txc,
    output logic        o_tx_valid,
    output logic [1:0]  o_link_fault,
    output logic        o_tx_truncated
);

    localparam int unsigned CW = $clog2(WINDOW + 1);
    localparam int unsigned SW = $clog2(THRESHOLD + 1);

    localparam logic [31:0] IDLE_D = 32'h07070707;
    localparam logic [3:0]  IDLE_C = 4'hF;
    localparam logic [31:0] RF_D   = 32'h0200009C;
    localparam logic [3:0]  RF_C   = 4'h1;

    typedef enum logic [1:0] {
        FT_NONE = 2'b00,
        FT_LF   = 2'b01,
        FT_RF   = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        TX_PASS,
        TX_RF,
        TX_IDLE
    } tx_state_e;

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [SW-1:0] seq_cnt_q, seq_cnt_d;
    fault_e        last_type_q, last_type_d;
    fault_e        link_fault_q, link_fault_d;
    tx_state_e     state_q, state_d;
    logic          in_frame_q, in_frame_d;
    logic [31:0]   txd_q, txd_d;
    logic [3:0]    txc_q, txc_d;
    logic          tx_valid_q, tx_valid_d;
    logic          trunc_q, trunc_d;

    logic          rx_is_fault;
    fault_e        rx_type;
    logic          tx_col_idle;

    // Classify the RX column: only an exact LF/RF sequence ordered set counts.
    always_comb begin
        rx_is_fault = 1'b0;
        rx_type     = FT_NONE;
        if (i_rxc == 4'b0001 && i_rxd[7:0] == 8'h9C && i_rxd[23:8] == 16'h0000) begin
            if (i_rxd[31:24] == 8'h01) begin
                rx_is_fault = 1'b1;
                rx_type     = FT_LF;
            end else if (i_rxd[31:24] == 8'h02) begin
                rx_is_fault = 1'b1;
                rx_type     = FT_RF;
            end
        end
    end

    // Count same-type fault sequences and the non-fault gap between them.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        seq_cnt_d    = seq_cnt_q;
        last_type_d  = last_type_q;
        link_fault_d = link_fault_q;
        if (i_rx_valid) begin
            if (rx_is_fault) begin
                if (rx_type == last_type_q && col_cnt_q < CW'(WINDOW)) begin
                    if (seq_cnt_q < SW'(THRESHOLD)) begin
                        seq_cnt_d = seq_cnt_q + SW'(1);
                    end
                end else begin
                    seq_cnt_d = SW'(1);
                end
                last_type_d = rx_type;
                col_cnt_d   = '0;
                if (seq_cnt_d == SW'(THRESHOLD)) begin
                    link_fault_d = rx_type;
                end
            end else if (col_cnt_q < CW'(WINDOW)) begin
                col_cnt_d = col_cnt_q + CW'(1);
                if (col_cnt_d == CW'(WINDOW)) begin
                    seq_cnt_d    = '0;
                    last_type_d  = FT_NONE;
                    link_fault_d = FT_NONE;
                end
            end
        end
    end

    assign tx_col_idle = (i_txc == IDLE_C) && (i_txd == IDLE_D);

    // TX sequencing: next state picks the column content, so substitution
    // starts on the same column that triggers the transition.
    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q;
        txd_d      = txd_q;
        txc_d      = txc_q;
        tx_valid_d = i_tx_valid;
        trunc_d    = 1'b0;
        if (i_tx_valid) begin
            if (i_txc[0] && i_txd[7:0] == 8'hFB) begin
                in_frame_d = 1'b1;
            end
            for (int unsigned l = 0; l < 4; l++) begin
                if (i_txc[l] && i_txd[8*l +: 8] == 8'hFD) begin
                    in_frame_d = 1'b0;
                end
            end
            case (state_q)
                TX_PASS: begin
                    if (link_fault_q == FT_LF)      state_d = TX_RF;
                    else if (link_fault_q == FT_RF) state_d = TX_IDLE;
                end
                TX_RF: begin
                    if (link_fault_q == FT_RF)                       state_d = TX_IDLE;
                    else if (link_fault_q == FT_NONE && tx_col_idle) state_d = TX_PASS;
                end
                TX_IDLE: begin
                    if (link_fault_q == FT_LF)                       state_d = TX_RF;
                    else if (link_fault_q == FT_NONE && tx_col_idle) state_d = TX_PASS;
                end
                default: state_d = TX_PASS;
            endcase
            if (state_q == TX_PASS && state_d != TX_PASS) begin
                trunc_d    = in_frame_q;
                in_frame_d = 1'b0;
            end
            case (state_d)
                TX_RF: begin
                    txd_d = RF_D;
                    txc_d = RF_C;
                end
                TX_IDLE: begin
                    txd_d = IDLE_D;
                    txc_d = IDLE_C;
                end
                default: begin
                    txd_d = i_txd;
                    txc_d = i_txc;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_cnt_q    <= '0;
            seq_cnt_q    <= '0;
            last_type_q  <= FT_NONE;
            link_fault_q <= FT_NONE;
            state_q      <= TX_PASS;
            in_frame_q   <= 1'b0;
            txd_q        <= IDLE_D;
            txc_q        <= IDLE_C;
            tx_valid_q   <= 1'b0;
            trunc_q      <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            seq_cnt_q    <= seq_cnt_d;
            last_type_q  <= last_type_d;
            link_fault_q <= link_fault_d;
            state_q      <= state_d;
            in_frame_q   <= in_frame_d;
            txd_q        <= txd_d;
            txc_q        <= txc_d;
            tx_valid_q   <= tx_valid_d;
            trunc_q      <= trunc_d;
        end
    end

    assign o_txd          = txd_q;
    assign o_txc          = txc_q;
    assign o_tx_valid     = tx_valid_q;
    assign o_link_fault   = link_fault_q;
    assign o_tx_truncated = trunc_q;

endmodule

// File: tb/tb_link_fault_sequencer.sv
// Testbench for link_fault_sequencer: scenario tasks with inline link-fault
// checks, and a scoreboard of expected TX columns compared on o_tx_valid.
module tb_link_fault_sequencer;

    localparam logic [31:0] IDLE_D  = 32'h07070707;
    localparam logic [3:0]  IDLE_C  = 4'hF;
    localparam logic [31:0] LF_D    = 32'h0100009C;
    localparam logic [31:0] RF_D    = 32'h0200009C;
    localparam logic [3:0]  FAULT_C = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_rxd;
    logic [3:0]  i_rxc;
    logic        i_rx_valid;
    logic [31:0] i_txd;
    logic [3:0]  i_txc;
    logic        i_tx_valid;
    logic [31:0] o_txd;
    logic [3:0]  o_txc;
    logic        o_tx_valid;
    logic [1:0]  o_link_fault;
    logic        o_tx_truncated;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] sb[$];
    logic [36:0] mon_exp;

    always #5 clk = ~clk;

    link_fault_sequencer #(.WINDOW(128), .THRESHOLD(4)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_rxd          (i_rxd),
        .i_rxc          (i_rxc),
        .i_rx_valid     (i_rx_valid),
        .i_txd          (i_txd),
        .i_txc          (i_txc),
        .i_tx_valid     (i_tx_valid),
        .o_txd          (o_txd),
        .o_txc          (o_txc),
        .o_tx_valid     (o_tx_valid),
        .o_link_fault   (o_link_fault),
        .o_tx_truncated (o_tx_truncated)
    );

    // Scoreboard: pop one expected column for every valid output column.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_tx_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got txd=%h txc=%h, expected no valid column", o_txd, o_txc);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({o_txd, o_txc, o_tx_truncated} !== mon_exp) begin
                        errors++;
                        $display("FAIL tx_column: got txd=%h txc=%h trunc=%b, expected txd=%h txc=%h trunc=%b",
                                 o_txd, o_txc, o_tx_truncated, mon_exp[36:5], mon_exp[4:1], mon_exp[0]);
                    end
                end
            end else if (o_tx_truncated !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL trunc_when_invalid: got %b, expected 0", o_tx_truncated);
            end
        end
    end

    task automatic drive(input logic [31:0] rd, input logic [3:0] rc, input logic rv,
                         input logic [31:0] td, input logic [3:0] tc, input logic tv,
                         input logic [31:0] ed, input logic [3:0] ec, input logic et);
        i_rxd      = rd;
        i_rxc      = rc;
        i_rx_valid = rv;
        i_txd      = td;
        i_txc      = tc;
        i_tx_valid = tv;
        if (tv) sb.push_back({ed, ec, et});
        @(posedge clk);
        #1;
    endtask

    task automatic rx_col(input logic [31:0] rd, input logic [3:0] rc, input logic rv);
        drive(rd, rc, rv, IDLE_D, IDLE_C, 1'b0, IDLE_D, IDLE_C, 1'b0);
    endtask

    task automatic do_reset();
        i_tx_valid = 1'b0;
        i_rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_fault(input string name, input logic [1:0] exp);
        checks++;
        if (o_link_fault !== exp) begin
            errors++;
            $display("FAIL %s: got link_fault=%b, expected %b", name, o_link_fault, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_rxd = IDLE_D; i_rxc = IDLE_C; i_rx_valid = 1'b0;
        i_txd = 32'hDEADBEEF; i_txc = 4'h0; i_tx_valid = 1'b1;
        #12;
        checks++; if (o_txd !== IDLE_D) begin errors++; $display("FAIL reset_txd: got %h, expected %h", o_txd, IDLE_D); end
        checks++; if (o_txc !== IDLE_C) begin errors++; $display("FAIL reset_txc: got %h, expected %h", o_txc, IDLE_C); end
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", o_tx_valid); end
        checks++; if (o_tx_truncated !== 1'b0) begin errors++; $display("FAIL reset_trunc: got %b, expected 0", o_tx_truncated); end
        check_fault("reset_fault", 2'b00);
        i_tx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lf_detect();
        logic [31:0] rd;
        logic [3:0]  rc;
        do_reset();
        for (int i = 0; i < 44; i++) begin
            rd = (i % 11 == 0) ? LF_D : IDLE_D;
            rc = (i % 11 == 0) ? FAULT_C : IDLE_C;
            if (i >= 34) drive(rd, rc, 1'b1, IDLE_D, IDLE_C, 1'b1, RF_D, FAULT_C, 1'b0);
            else         drive(rd, rc, 1'b1, IDLE_D, IDLE_C, 1'b1, IDLE_D, IDLE_C, 1'b0);
            if (i == 32) check_fault("lf_before_4th", 2'b00);
            if (i == 33) check_fault("lf_after_4th", 2'b01);
        end
    endtask

    task automatic test_window();
        do_reset();
        repeat (3) rx_col(LF_D, FAULT_C, 1'b1);
        repeat (128) rx_col(IDLE_D, IDLE_C, 1'b1);
        rx_col(LF_D, FAULT_C, 1'b1);
        check_fault("window_expired", 2'b00);
        repeat (2) rx_col(LF_D, FAULT_C, 1'b1);
        check_fault("window_restart_3", 2'b00);
        rx_col(LF_D, FAULT_C, 1'b1);
        check_fault("window_restart_4", 2'b01);
        do_reset();
        repeat (3) rx_col(LF_D, FAULT_C, 1'b1);
        repeat (127) rx_col(IDLE_D, IDLE_C, 1'b1);
        rx_col(LF_D, FAULT_C, 1'b1);
        check_fault("window_127_gap", 2'b01);
    endtask

    task automatic test_lf_then_rf();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd = (i < 2) ? LF_D : RF_D;
            if (i < 6) drive(rd, FAULT_C, 1'b1, 32'hA5A5A5A5, 4'h0, 1'b1, 32'hA5A5A5A5, 4'h0, 1'b0);
            else       drive(IDLE_D, IDLE_C, 1'b1, 32'hA5A5A5A5, 4'h0, 1'b1, IDLE_D, IDLE_C, 1'b0);
            if (i == 2) check_fault("mixed_after_1st_rf", 2'b00);
            if (i == 4) check_fault("mixed_after_3rd_rf", 2'b00);
            if (i == 5) check_fault("mixed_after_4th_rf", 2'b10);
        end
    endtask

    task automatic test_truncate();
        do_reset();
        drive(IDLE_D, IDLE_C, 1'b0, 32'h555555FB, 4'h1, 1'b1, 32'h555555FB, 4'h1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            drive(LF_D, FAULT_C, 1'b1, 32'hDEADBEEF, 4'h0, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0);
            if (i == 3) check_fault("trunc_before", 2'b00);
        end
        check_fault("trunc_fault", 2'b01);
        drive(IDLE_D, IDLE_C, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1, RF_D, FAULT_C, 1'b1);
        drive(IDLE_D, IDLE_C, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1, RF_D, FAULT_C, 1'b0);
    endtask

    task automatic test_recover_mid_frame();
        for (int n = 1; n <= 128; n++) begin
            rx_col(IDLE_D, IDLE_C, 1'b1);
            if (n == 127) check_fault("recover_127", 2'b01);
        end
        check_fault("recover_128", 2'b00);
        drive(IDLE_D, IDLE_C, 1'b0, 32'h555555FB, 4'h1, 1'b1, RF_D, FAULT_C, 1'b0);
        drive(IDLE_D, IDLE_C, 1'b0, 32'hDEADBEEF, 4'h0, 1'b1, RF_D, FAULT_C, 1'b0);
        drive(IDLE_D, IDLE_C, 1'b0, 32'h070707FD, 4'hF, 1'b1, RF_D, FAULT_C, 1'b0);
        drive(IDLE_D, IDLE_C, 1'b0, IDLE_D, IDLE_C, 1'b1, IDLE_D, IDLE_C, 1'b0);
        drive(IDLE_D, IDLE_C, 1'b0, 32'h12345678, 4'h0, 1'b1, 32'h12345678, 4'h0, 1'b0);
    endtask

    task automatic test_tx_stall();
        drive(IDLE_D, IDLE_C, 1'b0, 32'hCAFEF00D, 4'h3, 1'b0, IDLE_D, IDLE_C, 1'b0);
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b, expected 0", o_tx_valid); end
        checks++; if (o_txd !== 32'h12345678) begin errors++; $display("FAIL stall_txd_hold: got %h, expected 12345678", o_txd); end
        checks++; if (o_txc !== 4'h0) begin errors++; $display("FAIL stall_txc_hold: got %h, expected 0", o_txc); end
    endtask

    task automatic test_rx_stall();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rx_col(LF_D, FAULT_C, 1'b1);
            if (k == 2) check_fault("rx_stall_3rd", 2'b00);
            if (k < 3) repeat (200) rx_col(RF_D, FAULT_C, 1'b0);
        end
        check_fault("rx_stall_4th", 2'b01);
    endtask

    task automatic test_reset_mid_fault();
        drive(IDLE_D, IDLE_C, 1'b0, 32'hABCD0123, 4'h0, 1'b1, RF_D, FAULT_C, 1'b0);
        i_tx_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++; if (o_txd !== IDLE_D) begin errors++; $display("FAIL midrst_txd: got %h, expected %h", o_txd, IDLE_D); end
        checks++; if (o_txc !== IDLE_C) begin errors++; $display("FAIL midrst_txc: got %h, expected %h", o_txc, IDLE_C); end
        check_fault("midrst_fault", 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(IDLE_D, IDLE_C, 1'b0, 32'h11223344, 4'h0, 1'b1, 32'h11223344, 4'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lf_detect();
        test_window();
        test_reset_mid_fault();
        test_lf_then_rf();
        test_truncate();
        test_recover_mid_frame();
        test_tx_stall();
        test_rx_stall();
        i_tx_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending columns, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
